// File: rtl/dma_cfg_seq.sv
// Sequencer that turns one DMA transfer command into ordered AXI-Lite register writes.
// Optional build macro DMA_CFG_IRQ_EN: clears status and enables IOC/Err interrupts in CR.
module dma_cfg_seq #(
  parameter int unsigned LEN_W   = 26,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_chan,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [31:0]      lite_wdata,
  output logic [9:0]       lite_awaddr,
  output logic             lite_valid,
  input  logic             lite_end,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SR, S_WAIT_SR, S_WR_CR, S_WAIT_CR, S_WR_ADDR, S_WAIT_ADDR,
    S_WR_LEN, S_WAIT_LEN, S_DONE, S_ERR
  } state_e;

`ifdef DMA_CFG_IRQ_EN
  localparam state_e      FIRST_WR = S_WR_SR;
  localparam logic [31:0] CR_DATA  = 32'h0000_5001;
`else
  localparam state_e      FIRST_WR = S_WR_CR;
  localparam logic [31:0] CR_DATA  = 32'h0000_0001;
`endif
  localparam logic [31:0] SR_CLEAR = 32'h0000_5000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chan_q, chan_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [9:0]       awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;

  // S2MM register block sits 0x30 above the MM2S block
  function automatic logic [9:0] reg_off(input logic chan, input logic [9:0] base);
    return chan ? base + 10'h030 : base;
  endfunction

  function automatic state_e wait_of(input state_e s);
    case (s)
      S_WR_SR:   return S_WAIT_SR;
      S_WR_CR:   return S_WAIT_CR;
      S_WR_ADDR: return S_WAIT_ADDR;
      default:   return S_WAIT_LEN;
    endcase
  endfunction

  function automatic state_e next_wr(input state_e s);
    case (s)
      S_WAIT_SR:   return S_WR_CR;
      S_WAIT_CR:   return S_WR_ADDR;
      S_WAIT_ADDR: return S_WR_LEN;
      default:     return S_DONE;
    endcase
  endfunction

  // Next-state logic; outputs are decoded from the next state so they register alongside it
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chan_d   = chan_q;
    addr_d   = addr_q;
    len_d    = len_q;
    valid_d  = 1'b0;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          chan_d  = cmd_chan;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          state_d = FIRST_WR;
        end
      end
      S_WR_SR, S_WR_CR, S_WR_ADDR, S_WR_LEN: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? S_ERR : wait_of(state_q);
      end
      S_WAIT_SR, S_WAIT_CR, S_WAIT_ADDR, S_WAIT_LEN: begin
        if (lite_end) begin
          state_d = next_wr(state_q);
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);

    // A zero-length command parks one cycle in the first write state without a strobe
    if (len_d != '0) begin
      case (state_d)
        S_WR_SR: begin
          valid_d  = 1'b1;
          awaddr_d = reg_off(chan_d, 10'h004);
          wdata_d  = SR_CLEAR;
        end
        S_WR_CR: begin
          valid_d  = 1'b1;
          awaddr_d = reg_off(chan_d, 10'h000);
          wdata_d  = CR_DATA;
        end
        S_WR_ADDR: begin
          valid_d  = 1'b1;
          awaddr_d = reg_off(chan_d, 10'h018);
          wdata_d  = addr_d;
        end
        S_WR_LEN: begin
          valid_d  = 1'b1;
          awaddr_d = reg_off(chan_d, 10'h028);
          wdata_d  = 32'(len_d);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      chan_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign lite_valid  = valid_q;
  assign lite_awaddr = awaddr_q;
  assign lite_wdata  = wdata_q;

endmodule

// File: tb/tb_dma_cfg_seq.sv
// Scoreboard bench for dma_cfg_seq: expected writes/events queued at stimulus, checked by a monitor.
module tb_dma_cfg_seq;

  localparam int unsigned LEN_W = 26;
  localparam int unsigned TMO   = 15;
`ifdef DMA_CFG_IRQ_EN
  localparam int unsigned PRE  = 1;
  localparam logic [31:0] CR_D = 32'h0000_5001;
`else
  localparam int unsigned PRE  = 0;
  localparam logic [31:0] CR_D = 32'h0000_0001;
`endif

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_chan;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      lite_wdata;
  logic [9:0]       lite_awaddr;
  logic             lite_valid;
  logic             lite_end;
  logic             resp_end;
  logic             stray_end;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;

  assign lite_end = resp_end | stray_end;

  dma_cfg_seq #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .lite_wdata(lite_wdata), .lite_awaddr(lite_awaddr), .lite_valid(lite_valid),
    .lite_end(lite_end), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s: expected event did not occur or was unexpected (cycle %0d)", name, cyc);
  endtask

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  ev_q[$];   // 1 = done, 2 = err

  function automatic logic [9:0] off(input logic chan, input logic [9:0] b);
    return chan ? b + 10'h030 : b;
  endfunction

  function automatic wr_t mk(input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  task automatic push_writes(input logic chan, input logic [31:0] addr,
                             input logic [LEN_W-1:0] len, input int n);
    wr_t seq[$];
    if (PRE != 0) seq.push_back(mk(off(chan, 10'h004), 32'h0000_5000));
    seq.push_back(mk(off(chan, 10'h000), CR_D));
    seq.push_back(mk(off(chan, 10'h018), addr));
    seq.push_back(mk(off(chan, 10'h028), 32'(len)));
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
  endtask

  // Monitor: inputs are driven at negedge, so sample everything just after it
  int  last_trig = -10;
  wr_t mon_w;
  int  mon_e;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cmd_valid && cmd_ready) last_trig = cyc;
      if (lite_valid) begin
        if (exp_q.size() == 0) fail("unexpected_write");
        else begin
          mon_w = exp_q.pop_front();
          check("awaddr", 32'(lite_awaddr), 32'(mon_w.a));
          check("wdata", lite_wdata, mon_w.d);
          check("valid_latency", cyc, last_trig + 1);
        end
      end
      if (cfg_done || cfg_err) begin
        if (ev_q.size() == 0) fail("unexpected_done_err");
        else begin
          mon_e = ev_q.pop_front();
          check("done_err_kind", 32'({cfg_err, cfg_done}), mon_e);
          if (cfg_done) check("done_latency", cyc, last_trig + 1);
        end
      end
      if (lite_end) last_trig = cyc;
    end
  end

  // Responder: lite_end three cycles after each strobe unless that write is withheld
  int n_wr = 0;
  int withhold_at = 0;
  int due = -1;
  initial begin
    resp_end = 1'b0;
    forever begin
      @(negedge clk);
      resp_end = (cyc == due);
      if (lite_valid) begin
        n_wr++;
        if (n_wr != withhold_at) due = cyc + 3;
      end
    end
  end

  task automatic send(input logic chan, input logic [31:0] addr, input logic [LEN_W-1:0] len);
    int i;
    for (i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) fail("send_ready_timeout");
    cmd_valid = 1'b1;
    cmd_chan  = chan;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) fail("wait_idle_timeout");
  endtask

  task automatic wait_write(input logic [9:0] a, input string name);
    int i;
    for (i = 0; i < 100 && !(lite_valid && lite_awaddr == a); i++) @(negedge clk);
    if (!(lite_valid && lite_awaddr == a)) fail(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_lite_valid"}, 32'(lite_valid), 32'd0);
    check({tag, "_cfg_busy"}, 32'(cfg_busy), 32'd0);
    check({tag, "_cfg_done"}, 32'(cfg_done), 32'd0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_awaddr"}, 32'(lite_awaddr), 32'd0);
    check({tag, "_wdata"}, lite_wdata, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int addr_cyc;
    int err_cyc;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_chan  = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    stray_end = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Nominal MM2S
    push_writes(1'b0, 32'h1000_0000, 26'h400, 3 + PRE);
    ev_q.push_back(1);
    send(1'b0, 32'h1000_0000, 26'h400);
    wait_idle(200);
    check("ready_after_done", 32'(cmd_ready), 32'd1);

    // Zero length: busy for one cycle then err, no writes
    ev_q.push_back(2);
    send(1'b0, 32'hdead_beef, 26'h0);
    bc = 0;
    for (int i = 0; i < 5; i++) begin
      if (cfg_busy) bc++;
      @(negedge clk);
    end
    check("zero_len_busy_cycles", bc, 32'd1);
    wait_idle(20);

    // Timeout: withhold completion of the ADDR write
    withhold_at = n_wr + int'(PRE) + 2;
    push_writes(1'b0, 32'h0bad_f00d, 26'h80, int'(PRE) + 2);
    ev_q.push_back(2);
    send(1'b0, 32'h0bad_f00d, 26'h80);
    addr_cyc = -1;
    err_cyc  = -1;
    for (int i = 0; i < 200 && err_cyc < 0; i++) begin
      if (lite_valid && lite_awaddr == off(1'b0, 10'h018)) addr_cyc = cyc;
      if (cfg_err) err_cyc = cyc;
      @(negedge clk);
    end
    if (err_cyc < 0 || addr_cyc < 0) fail("timeout_err_missing");
    else check("timeout_wait_cycles", err_cyc - addr_cyc - 1, TMO);
    withhold_at = 0;
    wait_idle(20);

    // S2MM, also proves a command is accepted after a timeout
    push_writes(1'b1, 32'h2000_0040, 26'h3FF_FFFF, 3 + PRE);
    ev_q.push_back(1);
    send(1'b1, 32'h2000_0040, 26'h3FF_FFFF);
    wait_idle(200);

    // Command pulsed during WAIT_CR is ignored
    push_writes(1'b0, 32'h3000_0000, 26'h10, 3 + PRE);
    ev_q.push_back(1);
    send(1'b0, 32'h3000_0000, 26'h10);
    wait_write(off(1'b0, 10'h000), "cr_write_missing");
    @(negedge clk);
    check("ready_low_in_wait", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_chan  = 1'b1;
    cmd_addr  = 32'hffff_ffff;
    cmd_len   = 26'h5;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(200);

    // Stray lite_end in IDLE
    stray_end = 1'b1;
    @(negedge clk);
    stray_end = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_end_ready", 32'(cmd_ready), 32'd1);
    check("stray_end_busy", 32'(cfg_busy), 32'd0);

    // Reset while waiting on the ADDR write
    push_writes(1'b0, 32'h4000_0000, 26'h20, int'(PRE) + 2);
    send(1'b0, 32'h4000_0000, 26'h20);
    wait_write(off(1'b0, 10'h018), "addr_write_missing");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    repeat (10) @(negedge clk);
    check("midreset_still_idle", 32'(cmd_ready), 32'd1);

    check("writes_outstanding", exp_q.size(), 32'd0);
    check("events_outstanding", ev_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
